// File: rtl/regfile_pkg.sv
// Shared register-file constants and helpers for the write-port decode path.
// Imported by the one-hot decoder and the multi-port write decoder.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;
    localparam int ZERO_REG   = 0;

    // Ceiling log2, with a floor of 1 so a single-entry index still has a bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((2 ** result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Enable + address to one-hot decoder for a single register-file write port.
// Purely combinational; the output is all zeros when en is low.
module onehot_decoder
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                 en,
    input  logic [ADDR_W-1:0]    addr,
    output logic [2**ADDR_W-1:0] onehot
);

    always_comb begin
        // NOTE: assign a default before any conditional write so no latch is inferred.
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/wport_decoder.sv
// Multi-port register-file write-enable decoder: per-port one-hot decode,
// highest-port-wins merge, conflict detection, optional output stage and counter.
module wport_decoder
    import regfile_pkg::*;
#(
    parameter int ADDR_W      = REG_ADDR_W,
    parameter int NUM_PORTS   = 2,
    parameter int ZERO_REG_RO = 1,
    parameter int REGISTERED  = 1,
    parameter int CNT_W       = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          stall,
    input  logic [NUM_PORTS-1:0]          in_valid,
    input  logic [NUM_PORTS*ADDR_W-1:0]   in_addr,
    output logic [2**ADDR_W-1:0]          wen,
    output logic [NUM_PORTS-1:0]          grant,
    output logic                          conflict,
    output logic [CNT_W-1:0]              conflict_count
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [NUM_PORTS-1:0][NREGS-1:0] raw;
    logic [NUM_PORTS-1:0][NREGS-1:0] masked;
    logic [NUM_PORTS-1:0]            live;
    logic [NREGS-1:0]                wen_d;
    logic [NUM_PORTS-1:0]            grant_d;
    logic                            conflict_d;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
        onehot_decoder #(
            .ADDR_W (ADDR_W)
        ) u_dec (
            .en     (in_valid[p]),
            .addr   (in_addr[p*ADDR_W +: ADDR_W]),
            .onehot (raw[p])
        );
    end

    // Two live ports collide exactly when their masked one-hots are equal;
    // the lower-indexed one yields, so the highest port always wins.
    always_comb begin
        masked     = raw;
        live       = '0;
        wen_d      = '0;
        grant_d    = '0;
        conflict_d = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (ZERO_REG_RO != 0) begin
                masked[p][ZERO_REG] = 1'b0;
            end
            live[p] = |masked[p];
            wen_d   = wen_d | masked[p];
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            grant_d[p] = live[p];
            for (int q = p + 1; q < NUM_PORTS; q++) begin
                if (live[p] && live[q] && (masked[p] == masked[q])) begin
                    grant_d[p] = 1'b0;
                    conflict_d = 1'b1;
                end
            end
        end
    end

    if (REGISTERED != 0) begin : g_reg
        // NOTE: registered state uses non-blocking assignments only.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                wen      <= '0;
                grant    <= '0;
                conflict <= 1'b0;
            end else if (!stall) begin
                wen      <= wen_d;
                grant    <= grant_d;
                conflict <= conflict_d;
            end
        end
    end else begin : g_comb
        // A stall suppresses the write itself but still reports the conflict.
        always_comb begin
            wen      = (reset || stall) ? '0 : wen_d;
            grant    = (reset || stall) ? '0 : grant_d;
            conflict = reset ? 1'b0 : conflict_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conflict_count <= '0;
        end else if (conflict_d && !stall && (conflict_count != {CNT_W{1'b1}})) begin
            conflict_count <= conflict_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wport_decoder.sv
// Bench for wport_decoder: five parameter variants share one stimulus stream and
// are checked every cycle against a register-by-register behavioural model.
module tb_wport_decoder;

    typedef struct packed {
        logic [31:0] wen;
        logic [1:0]  grant;
        logic        conf;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       stall = 1'b0;
    logic [1:0] in_valid = 2'b00;
    logic [4:0] a0 = '0;
    logic [4:0] a1 = '0;
    logic [9:0] in_addr;
    assign in_addr = {a1, a0};

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // main: 2 ports, zero reg read-only, registered
    logic [31:0] wen_m;  logic [1:0] grant_m;  logic conf_m;  logic [15:0] cnt_m;
    // one: single port
    logic [31:0] wen_1;  logic [0:0] grant_1;  logic conf_1;  logic [15:0] cnt_1;
    // zero: register 0 writable
    logic [31:0] wen_z;  logic [1:0] grant_z;  logic conf_z;  logic [15:0] cnt_z;
    // sat: 3-bit counter
    logic [31:0] wen_s;  logic [1:0] grant_s;  logic conf_s;  logic [2:0]  cnt_s;
    // comb: unregistered outputs
    logic [31:0] wen_c;  logic [1:0] grant_c;  logic conf_c;  logic [15:0] cnt_c;

    wport_decoder #(.ADDR_W(5), .NUM_PORTS(2), .ZERO_REG_RO(1), .REGISTERED(1), .CNT_W(16)) dut_m (
        .clock(clock), .reset(reset), .stall(stall), .in_valid(in_valid), .in_addr(in_addr),
        .wen(wen_m), .grant(grant_m), .conflict(conf_m), .conflict_count(cnt_m));

    wport_decoder #(.ADDR_W(5), .NUM_PORTS(1), .ZERO_REG_RO(1), .REGISTERED(1), .CNT_W(16)) dut_1 (
        .clock(clock), .reset(reset), .stall(stall), .in_valid(in_valid[0:0]), .in_addr(in_addr[4:0]),
        .wen(wen_1), .grant(grant_1), .conflict(conf_1), .conflict_count(cnt_1));

    wport_decoder #(.ADDR_W(5), .NUM_PORTS(2), .ZERO_REG_RO(0), .REGISTERED(1), .CNT_W(16)) dut_z (
        .clock(clock), .reset(reset), .stall(stall), .in_valid(in_valid), .in_addr(in_addr),
        .wen(wen_z), .grant(grant_z), .conflict(conf_z), .conflict_count(cnt_z));

    wport_decoder #(.ADDR_W(5), .NUM_PORTS(2), .ZERO_REG_RO(1), .REGISTERED(1), .CNT_W(3)) dut_s (
        .clock(clock), .reset(reset), .stall(stall), .in_valid(in_valid), .in_addr(in_addr),
        .wen(wen_s), .grant(grant_s), .conflict(conf_s), .conflict_count(cnt_s));

    wport_decoder #(.ADDR_W(5), .NUM_PORTS(2), .ZERO_REG_RO(1), .REGISTERED(0), .CNT_W(16)) dut_c (
        .clock(clock), .reset(reset), .stall(stall), .in_valid(in_valid), .in_addr(in_addr),
        .wen(wen_c), .grant(grant_c), .conflict(conf_c), .conflict_count(cnt_c));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // For each register, list the live ports aiming at it; the highest one wins.
    function automatic exp_t mdl(input logic [1:0] v, input logic [4:0] p0, input logic [4:0] p1,
                                 input int np, input bit ro);
        exp_t e;
        int   tgt [2];
        int   n;
        int   hi;
        e = '0;
        tgt[0] = int'(p0);
        tgt[1] = int'(p1);
        for (int r = 0; r < 32; r++) begin
            if (!(ro && r == 0)) begin
                n  = 0;
                hi = 0;
                for (int p = 0; p < np; p++) begin
                    if (v[p] && tgt[p] == r) begin
                        n++;
                        hi = p;
                    end
                end
                if (n > 0) begin
                    e.wen[r]    = 1'b1;
                    e.grant[hi] = 1'b1;
                end
                if (n > 1) e.conf = 1'b1;
            end
        end
        return e;
    endfunction

    // Expected registered outputs and counters.
    exp_t em, e1, ez;
    int   cm, c1, cz, cs;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            em <= '0; e1 <= '0; ez <= '0;
            cm <= 0;  c1 <= 0;  cz <= 0;  cs <= 0;
        end else if (!stall) begin
            em <= mdl(in_valid, a0, a1, 2, 1'b1);
            e1 <= mdl({1'b0, in_valid[0]}, a0, a1, 1, 1'b1);
            ez <= mdl(in_valid, a0, a1, 2, 1'b0);
            if (mdl(in_valid, a0, a1, 2, 1'b1).conf) begin
                cm <= cm + 1;
                cs <= (cs >= 7) ? 7 : cs + 1;
            end
            if (mdl({1'b0, in_valid[0]}, a0, a1, 1, 1'b1).conf) c1 <= c1 + 1;
            if (mdl(in_valid, a0, a1, 2, 1'b0).conf) cz <= cz + 1;
        end
    end

    always @(negedge clock) begin
        exp_t ec;
        ec = mdl(in_valid, a0, a1, 2, 1'b1);
        if (reset) ec = '0;
        else if (stall) begin
            ec.wen   = '0;
            ec.grant = '0;
        end
        check("main_wen",   64'(wen_m),   64'(em.wen));
        check("main_grant", 64'(grant_m), 64'(em.grant));
        check("main_conf",  64'(conf_m),  64'(em.conf));
        check("main_cnt",   64'(cnt_m),   64'(cm));
        check("one_wen",    64'(wen_1),   64'(e1.wen));
        check("one_grant",  64'(grant_1), 64'(e1.grant[0]));
        check("one_conf",   64'(conf_1),  64'(e1.conf));
        check("one_cnt",    64'(cnt_1),   64'(c1));
        check("zero_wen",   64'(wen_z),   64'(ez.wen));
        check("zero_grant", 64'(grant_z), 64'(ez.grant));
        check("zero_conf",  64'(conf_z),  64'(ez.conf));
        check("zero_cnt",   64'(cnt_z),   64'(cz));
        check("sat_wen",    64'(wen_s),   64'(em.wen));
        check("sat_cnt",    64'(cnt_s),   64'(cs));
        check("comb_wen",   64'(wen_c),   64'(ec.wen));
        check("comb_grant", 64'(grant_c), 64'(ec.grant));
        check("comb_conf",  64'(conf_c),  64'(ec.conf));
        check("comb_cnt",   64'(cnt_c),   64'(cm));
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [4:0] p0, input logic [4:0] p1, input logic st);
        in_valid = v;
        a0       = p0;
        a1       = p1;
        stall    = st;
    endtask

    initial begin
        logic [31:0] expw;

        repeat (2) @(posedge clock);
        #1;
        check("reset_wen",   64'(wen_m),   64'h0);
        check("reset_grant", 64'(grant_m), 64'h0);
        check("reset_cnt",   64'(cnt_m),   64'h0);
        reset = 1'b0;

        // Single-port sweep over every address.
        for (int a = 0; a < 32; a++) begin
            drive(2'b01, 5'(a), 5'd0, 1'b0);
            tick();
            expw = 32'h1 << a;
            if (a == 0) expw = 32'h0;
            check("sweep_wen",   64'(wen_1),   64'(expw));
            check("sweep_grant", 64'(grant_1), (a == 0) ? 64'h0 : 64'h1);
        end

        // Distinct targets.
        drive(2'b11, 5'd3, 5'd7, 1'b0);
        tick();
        check("dist_wen",   64'(wen_m),   64'h88);
        check("dist_grant", 64'(grant_m), 64'h3);
        check("dist_conf",  64'(conf_m),  64'h0);
        check("dist_cnt",   64'(cnt_m),   64'h0);

        // Collision on register 9, three cycles.
        drive(2'b11, 5'd9, 5'd9, 1'b0);
        #1;
        check("comb_coll_wen",   64'(wen_c),   64'h200);
        check("comb_coll_grant", 64'(grant_c), 64'h2);
        check("comb_coll_conf",  64'(conf_c),  64'h1);
        repeat (3) tick();
        check("coll_wen",   64'(wen_m),   64'h200);
        check("coll_grant", 64'(grant_m), 64'h2);
        check("coll_conf",  64'(conf_m),  64'h1);
        check("coll_cnt",   64'(cnt_m),   64'h3);

        // Both ports on register 0.
        drive(2'b11, 5'd0, 5'd0, 1'b0);
        tick();
        check("zero_ro_wen",   64'(wen_m),   64'h0);
        check("zero_ro_grant", 64'(grant_m), 64'h0);
        check("zero_ro_conf",  64'(conf_m),  64'h0);
        check("zero_ro_cnt",   64'(cnt_m),   64'h3);
        check("zero_rw_wen",   64'(wen_z),   64'h1);
        check("zero_rw_grant", 64'(grant_z), 64'h2);
        check("zero_rw_conf",  64'(conf_z),  64'h1);
        check("zero_rw_cnt",   64'(cnt_z),   64'h4);

        // Stall holds the captured write and freezes the counter.
        drive(2'b01, 5'd5, 5'd0, 1'b0);
        tick();
        check("pre_stall_wen", 64'(wen_m), 64'h20);
        drive(2'b11, 5'd12, 5'd12, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_wen",      64'(wen_m), 64'h20);
            check("stall_cnt",      64'(cnt_m), 64'h3);
            check("stall_comb_wen", 64'(wen_c), 64'h0);
        end
        stall = 1'b0;
        tick();
        check("post_stall_wen",   64'(wen_m),   64'h1000);
        check("post_stall_grant", 64'(grant_m), 64'h2);
        check("post_stall_cnt",   64'(cnt_m),   64'h4);

        // Counter saturation.
        drive(2'b11, 5'd9, 5'd9, 1'b0);
        repeat (10) tick();
        check("sat_cnt7",  64'(cnt_s), 64'h7);
        check("main_cnt14", 64'(cnt_m), 64'd14);

        // Asynchronous reset in the middle of a cycle.
        #3;
        reset = 1'b1;
        #1;
        check("async_wen",   64'(wen_m),   64'h0);
        check("async_grant", 64'(grant_m), 64'h0);
        check("async_conf",  64'(conf_m),  64'h0);
        check("async_cnt",   64'(cnt_m),   64'h0);
        check("async_cnt_s", 64'(cnt_s),   64'h0);
        tick();
        reset = 1'b0;
        drive(2'b11, 5'd1, 5'd31, 1'b0);
        tick();
        check("after_rst_wen", 64'(wen_m), 64'h80000002);
        drive(2'b00, 5'd0, 5'd0, 1'b0);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wport_decoder.md
Name: wport_decoder

Overview:
- Parametrised, pipelined write-enable decoder for the register file, replacing the single 5-to-32 combinational decoder.
- Accepts NUM_PORTS independent write requests (valid + address) per cycle and produces one merged one-hot write-enable vector for the register array.
- Also produces per-port grant bits and conflict reporting.
- Optionally masks the hard-wired zero register.
- Optional output register stage; held by a pipeline stall.

Parameters:
ADDR_W, 5, register address width; the array has NUM_REGS = 2**ADDR_W entries
NUM_PORTS, 2, number of write ports (1..4)
ZERO_REG_RO, 1, 1 = register 0 is read-only; a write to address 0 is dropped
REGISTERED, 1, 1 = outputs registered (latency 1); 0 = outputs combinational (latency 0)
CNT_W, 16, width of the saturating conflict counter

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
stall  in  1  1 = hold the output stage; no new requests captured
in_valid  in  NUM_PORTS  per-port write request
in_addr  in  NUM_PORTS*ADDR_W  per-port address; port p occupies bits [p*ADDR_W +: ADDR_W]
wen  out  NUM_REGS  merged one-hot write enable (at most one bit set per register)
grant  out  NUM_PORTS  port p's write is committed this cycle
conflict  out  1  two or more valid ports targeted the same writable register
conflict_count  out  CNT_W  saturating count of cycles with conflict=1

Behaviour:
- Reset (asynchronous, any time, including mid-stall): wen=0, grant=0, conflict=0, conflict_count=0. All state clears immediately; the first capture occurs on the first rising edge after reset deasserts.
- Per-port decode: the raw one-hot for port p is 1<<in_addr[p] when in_valid[p]=1, otherwise 0.
- Zero-register masking (ZERO_REG_RO=1): bit 0 of each port's raw one-hot is forced to 0, and that port's grant is 0.
  - A write to address 0 never contributes to conflict.
  - With ZERO_REG_RO=0, register 0 is treated like any other register.
- Priority: when several valid ports target the same register, the highest-indexed port wins.
  - The winner's grant=1; every losing port's grant=0.
  - wen has exactly that register's bit set.
- Distinct targets: every valid, non-masked port gets grant=1, and wen is the OR of their one-hots.
- conflict = 1 iff at least one pair of valid, non-masked ports share an address.
- REGISTERED=1:
  - When stall=0, wen, grant and conflict are captured on the rising edge and appear one cycle after the request.
  - When stall=1, all three hold their previous values and the inputs are ignored.
- REGISTERED=0:
  - wen, grant and conflict follow the inputs combinationally.
  - stall forces wen=0 and grant=0, so no write happens during a stall. conflict still reflects the inputs.
- conflict_count increments by 1 on each rising edge where the (pre-register) conflict term is 1 and stall=0. It saturates at 2**CNT_W-1 and never wraps.
- NUM_PORTS=1: grant mirrors the valid, non-masked request; conflict and conflict_count are constant 0.
- X/invalid addresses are impossible by construction: every ADDR_W value is a valid register.

Decomposition:
- Package regfile_pkg holds:
  - REG_ADDR_W (default 5)
  - NUM_REGS
  - ZERO_REG index constant (0)
  - clog2 helper function
- Sub-module onehot_decoder (parameter ADDR_W): a purely combinational enable + address to one-hot decoder, instantiated NUM_PORTS times in a generate loop.
- Priority merge, conflict detection, output stage and counter live in wport_decoder.

Test Plan:
- Sweep, NUM_PORTS=1, REGISTERED=1: in_addr stepped 0..31 with in_valid=1 -> one cycle later wen=1<<addr for addr 1..31, and wen=0, grant=0 for addr 0.
- Distinct targets: port0 addr=3, port1 addr=7, both valid -> next cycle wen=0x00000088, grant=2'b11, conflict=0, conflict_count unchanged.
- Collision: both ports addr=9, valid -> wen=0x00000200, grant=2'b10, conflict=1. Repeated 3 cycles -> conflict_count=3.
- Zero register: both ports addr=0 -> wen=0, grant=0, conflict=0, count unchanged. Repeat with ZERO_REG_RO=0 -> wen=0x1, grant=2'b10, conflict=1.
- Stall: capture port0 addr=5, then stall=1 for 4 cycles while inputs change to addr=12 -> wen stays 0x20 and the counter is frozen. After stall=0 -> wen=0x1000.
- Reset and saturation:
  - With CNT_W=3, drive 10 conflicting cycles -> conflict_count=7.
  - Assert reset mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
